// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control bundles, field order as declared in pipe_ctrl_t
    localparam pipe_ctrl_t CTRL_HOLD     = 7'b0000_111;
    localparam pipe_ctrl_t CTRL_FREEZE   = 7'b0000_001;
    localparam pipe_ctrl_t CTRL_FLUSH    = 7'b1111_110;
    localparam pipe_ctrl_t CTRL_LOAD_USE = 7'b0011_010;
    localparam pipe_ctrl_t CTRL_RUN      = 7'b1111_000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID source register that depends on a load still in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    output logic       load_use
);

    assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipe; PIPE_PERF_CNT_EN adds hazard perf counters.
// state    | meaning
// HOLD     | post-reset window, pipe held empty
// RUN      | normal issue; branch flush and load-use bubble resolved here
// MEM_WAIT | data memory stalled, whole pipe frozen until mem_ready
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned RESET_HOLD_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT       = 64,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             mem_err,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] wait_cycles,
`endif
    output logic [1:0]       state
);

    if (RESET_HOLD_CYCLES < 1 || RESET_HOLD_CYCLES > 15 ||
        MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: parameter out of legal range");
    end

    localparam logic [3:0] HOLD_LOAD  = 4'(RESET_HOLD_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

    pipe_state_t state_q;
    logic [3:0]  hold_cnt;
    logic [7:0]  wait_cnt;
    logic        load_use;
    logic        freeze;
    pipe_ctrl_t  ctrl;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .load_use    (load_use)
    );

    assign freeze = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HOLD;
            hold_cnt <= HOLD_LOAD;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_cnt == 4'd0) state_q <= RUN;
                    else                  hold_cnt <= hold_cnt - 4'd1;
                end
                RUN: begin
                    if (freeze) begin
                        state_q  <= MEM_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (freeze) begin
                        wait_cnt <= sat_inc8(wait_cnt);
                        // set on the edge where the count reaches MEM_TIMEOUT
                        if (wait_cnt >= TIMEOUT_M1) mem_err <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= HOLD;
            endcase
        end
    end

    // Zero-latency decode; freeze outranks branch, branch outranks load-use
    always_comb begin
        ctrl   = CTRL_HOLD;
        pc_sel = 1'b0;
        if (state_q != HOLD) begin
            if (freeze) begin
                ctrl = CTRL_FREEZE;
            end else if (ex_branch_taken) begin
                ctrl   = CTRL_FLUSH;
                pc_sel = 1'b1;
            end else if (load_use) begin
                ctrl = CTRL_LOAD_USE;
            end else begin
                ctrl = CTRL_RUN;
            end
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign idex_write   = ctrl.idex_write;
    assign exmem_write  = ctrl.exmem_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign state        = state_q;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            wait_cycles  <= '0;
        end else if (state_q != HOLD) begin
            if (freeze) begin
                if (wait_cycles != '1) wait_cycles <= wait_cycles + 1'b1;
            end else if (ex_branch_taken) begin
                if (flush_count != '1) flush_count <= flush_count + 1'b1;
            end else if (load_use) begin
                if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule
